// File: rtl/soc_test_mailbox_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : soc_test_mailbox_pkg
//  Description : Register offsets, response type and byte-enable helper for
//                the test-status mailbox.
//  Revision    : 1.0 - initial release
// ============================================================================
package soc_test_mailbox_pkg;

    localparam logic [11:0] OFS_FLAG   = 12'h000;
    localparam logic [11:0] OFS_RESULT = 12'h004;
    localparam logic [11:0] OFS_SIGNAL = 12'h008;
    localparam logic [11:0] OFS_CYCLES = 12'h00C;
    localparam logic [11:0] OFS_WDOG   = 12'h010;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    // Merge write data into an existing word, one byte lane per enable bit
    function automatic logic [31:0] apply_be(
        input logic [31:0] old_val,
        input logic [31:0] wdata,
        input logic [3:0]  be
    );
        logic [31:0] merged;
        merged = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage
`default_nettype wire

// File: rtl/soc_test_mailbox_if.sv
`default_nettype none
// ============================================================================
//  Module      : soc_test_mailbox_if
//  Description : Core data-bus request/response bundle seen by the mailbox.
//  Revision    : 1.0 - initial release
// ============================================================================
interface soc_test_mailbox_if;

    logic        data_req_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_addr_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_wdata_i;
    logic [31:0] data_rdata_o;
    logic        data_err_o;

    modport master (
        output data_req_i,
        output data_addr_i,
        output data_we_i,
        output data_be_i,
        output data_wdata_i,
        input  data_gnt_o,
        input  data_rvalid_o,
        input  data_rdata_o,
        input  data_err_o
    );

    modport slave (
        input  data_req_i,
        input  data_addr_i,
        input  data_we_i,
        input  data_be_i,
        input  data_wdata_i,
        output data_gnt_o,
        output data_rvalid_o,
        output data_rdata_o,
        output data_err_o
    );

endinterface
`default_nettype wire

// File: rtl/mailbox_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : mailbox_watchdog
//  Description : Saturating cycle counter with equality-compare expiry pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module mailbox_watchdog (
    input  wire logic        clk_i,
    input  wire logic        rst_ni,
    input  wire logic        count_en_i,
    input  wire logic [31:0] limit_i,
    output logic [31:0]      cycles_o,
    output logic             expire_o
);

    logic [31:0] r_cycles;
    logic        w_saturated;
    logic [32:0] w_cycles_inc;

    assign w_saturated  = &r_cycles;
    assign w_cycles_inc = {1'b0, r_cycles} + 33'd1;

    // Equality only: a limit lowered below the running count never fires
    assign expire_o = count_en_i && (limit_i != 32'd0) &&
                      (w_cycles_inc == {1'b0, limit_i});

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cycles <= 32'd0;
        end else if (count_en_i && !w_saturated) begin
            r_cycles <= w_cycles_inc[31:0];
        end
    end

    assign cycles_o = r_cycles;

endmodule
`default_nettype wire

// File: rtl/soc_test_mailbox.sv
`default_nettype none
// ============================================================================
//  Module      : soc_test_mailbox
//  Description : Memory-mapped test-status responder with completion flag,
//                result word, signal bit, cycle counter and watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module soc_test_mailbox
    import soc_test_mailbox_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'h0010_0000,
    parameter logic [31:0] TIMEOUT_DEFAULT = 32'd100,
    parameter logic [31:0] TIMEOUT_CODE    = 32'h0000_0002,
    parameter logic [31:0] TIMEOUT_RESULT  = 32'hDEAD_BEEF
) (
    input  wire logic         clk_i,
    input  wire logic         rst_ni,
    input  wire logic         fetch_enable_i,
    soc_test_mailbox_if.slave bus,
    output logic [31:0]       mem_flag,
    output logic [31:0]       mem_result,
    output logic              signal,
    output logic              timeout_o
);

    logic [31:0] r_flag;
    logic [31:0] r_result;
    logic [31:0] r_wdog;
    logic        r_signal;
    logic        r_timeout;
    resp_t       r_resp;

    resp_t       w_resp_next;
    logic [11:0] w_ofs;
    logic        w_reg_mapped;
    logic        w_hit;
    logic        w_wr;
    logic        w_rd;
    logic [31:0] w_flag_merged;
    logic        w_fw_flag_set;
    logic        w_count_en;
    logic [31:0] w_cycles;
    logic        w_expire;
    logic [31:0] w_rd_mux;

    assign bus.data_gnt_o = bus.data_req_i;
    assign w_ofs          = bus.data_addr_i[11:0];

    always_comb begin
        w_reg_mapped = 1'b0;
        case (w_ofs)
            OFS_FLAG, OFS_RESULT, OFS_SIGNAL, OFS_CYCLES, OFS_WDOG: w_reg_mapped = 1'b1;
            default:                                                 w_reg_mapped = 1'b0;
        endcase
    end

    assign w_hit = (bus.data_addr_i[31:12] == BASE_ADDR[31:12]) &&
                   (bus.data_addr_i[1:0] == 2'b00) && w_reg_mapped;
    assign w_wr  = bus.data_req_i &&  bus.data_we_i && w_hit;
    assign w_rd  = bus.data_req_i && !bus.data_we_i && w_hit;

    // A firmware FLAG write only counts as completion if it leaves FLAG non-zero
    assign w_flag_merged = apply_be(r_flag, bus.data_wdata_i, bus.data_be_i);
    assign w_fw_flag_set = w_wr && (w_ofs == OFS_FLAG) && (r_flag == 32'd0) &&
                           (w_flag_merged != 32'd0);
    assign w_count_en    = fetch_enable_i && (r_flag == 32'd0);

    mailbox_watchdog u_watchdog (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .count_en_i (w_count_en),
        .limit_i    (r_wdog),
        .cycles_o   (w_cycles),
        .expire_o   (w_expire)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_flag    <= 32'd0;
            r_result  <= 32'd0;
            r_wdog    <= TIMEOUT_DEFAULT;
            r_signal  <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if (w_fw_flag_set) begin
                r_flag <= w_flag_merged;
            end
            if (w_wr && (w_ofs == OFS_RESULT) && (r_flag == 32'd0)) begin
                r_result <= apply_be(r_result, bus.data_wdata_i, bus.data_be_i);
            end
            if (w_wr && (w_ofs == OFS_SIGNAL) && bus.data_be_i[0]) begin
                r_signal <= bus.data_wdata_i[0];
            end
            if (w_wr && (w_ofs == OFS_WDOG)) begin
                r_wdog <= apply_be(r_wdog, bus.data_wdata_i, bus.data_be_i);
            end
            // Expiry overrides a same-cycle RESULT write but yields to a FLAG write
            if (w_expire && !w_fw_flag_set) begin
                r_flag    <= TIMEOUT_CODE;
                r_result  <= TIMEOUT_RESULT;
                r_timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        w_rd_mux = 32'd0;
        case (w_ofs)
            OFS_FLAG:   w_rd_mux = r_flag;
            OFS_RESULT: w_rd_mux = r_result;
            OFS_SIGNAL: w_rd_mux = {31'd0, r_signal};
            OFS_CYCLES: w_rd_mux = w_cycles;
            OFS_WDOG:   w_rd_mux = r_wdog;
            default:    w_rd_mux = 32'd0;
        endcase
    end

    always_comb begin
        w_resp_next       = '0;
        w_resp_next.valid = bus.data_req_i;
        w_resp_next.err   = bus.data_req_i && !w_hit;
        w_resp_next.rdata = w_rd ? w_rd_mux : 32'd0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_resp <= '0;
        end else begin
            r_resp <= w_resp_next;
        end
    end

    assign bus.data_rvalid_o = r_resp.valid;
    assign bus.data_err_o    = r_resp.err;
    assign bus.data_rdata_o  = r_resp.rdata;

    assign mem_flag   = r_flag;
    assign mem_result = r_result;
    assign signal     = r_signal;
    assign timeout_o  = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_soc_test_mailbox.sv
`default_nettype none
// ============================================================================
//  Module      : tb_soc_test_mailbox
//  Description : Randomised and directed bench for soc_test_mailbox against a
//                behavioural register model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_soc_test_mailbox;

    localparam logic [31:0] c_base = 32'h0010_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fe = 1'b0;
    logic [31:0] mem_flag;
    logic [31:0] mem_result;
    logic        signal;
    logic        timeout;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    logic [31:0] m_flag, m_result, m_wdog, m_cycles;
    logic        m_signal, m_timeout;

    always #5 clk = ~clk;

    soc_test_mailbox_if bus ();

    soc_test_mailbox dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .fetch_enable_i (fe),
        .bus            (bus),
        .mem_flag       (mem_flag),
        .mem_result     (mem_result),
        .signal         (signal),
        .timeout_o      (timeout)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lane_merge(input logic [31:0] old_v, input logic [31:0] wd,
                                               input logic [3:0] be);
        logic [31:0] mask;
        mask = 32'd0;
        for (int i = 0; i < 4; i++) if (be[i]) mask = mask | (32'hFF << (8 * i));
        return (old_v & ~mask) | (wd & mask);
    endfunction

    function automatic bit is_hit(input logic [31:0] a);
        logic [31:0] ofs;
        ofs = a & 32'hFFF;
        if ((a >> 12) != (c_base >> 12)) return 1'b0;
        if ((a % 4) != 0) return 1'b0;
        return (ofs == 32'h0) || (ofs == 32'h4) || (ofs == 32'h8) ||
               (ofs == 32'hC) || (ofs == 32'h10);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] ofs);
        case (ofs)
            32'h0:   return m_flag;
            32'h4:   return m_result;
            32'h8:   return {31'd0, m_signal};
            32'hC:   return m_cycles;
            32'h10:  return m_wdog;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_flag = 32'd0; m_result = 32'd0; m_wdog = 32'd100; m_cycles = 32'd0;
        m_signal = 1'b0; m_timeout = 1'b0;
    endtask

    task automatic bus_idle();
        bus.data_req_i = 1'b0; bus.data_we_i = 1'b0; bus.data_be_i = 4'h0;
        bus.data_addr_i = 32'd0; bus.data_wdata_i = 32'd0;
    endtask

    // One clock of traffic: drive, predict from the rules, advance, compare
    task automatic cycle(input bit req, input bit we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd);
        bit          hit, cnt, expire, fw_set;
        logic [31:0] ofs, e_rdata, n_flag, n_result, n_wdog, n_cycles, merged;
        logic [63:0] inc;
        logic        n_signal, n_timeout, e_err;
        bus.data_req_i = req; bus.data_we_i = we; bus.data_addr_i = addr;
        bus.data_be_i = be; bus.data_wdata_i = wd;
        #1;
        check_eq("gnt", {31'd0, bus.data_gnt_o}, {31'd0, req});
        hit     = is_hit(addr);
        ofs     = addr & 32'hFFF;
        e_err   = req && !hit;
        e_rdata = (req && !we && hit) ? model_read(ofs) : 32'd0;
        n_flag = m_flag; n_result = m_result; n_wdog = m_wdog; n_signal = m_signal;
        n_timeout = m_timeout; fw_set = 1'b0;
        cnt    = fe && (m_flag == 32'd0);
        inc    = {32'd0, m_cycles} + 64'd1;
        n_cycles = (cnt && inc <= 64'hFFFF_FFFF) ? inc[31:0] : m_cycles;
        expire = cnt && (m_wdog != 32'd0) && (inc == {32'd0, m_wdog});
        if (req && we && hit) begin
            case (ofs)
                32'h0: begin
                    merged = lane_merge(m_flag, wd, be);
                    if (m_flag == 32'd0 && merged != 32'd0) begin
                        n_flag = merged; fw_set = 1'b1;
                    end
                end
                32'h4:  if (m_flag == 32'd0) n_result = lane_merge(m_result, wd, be);
                32'h8:  if (be[0]) n_signal = wd[0];
                32'h10: n_wdog = lane_merge(m_wdog, wd, be);
                default: ;
            endcase
        end
        if (expire && !fw_set) begin
            n_flag = 32'h2; n_result = 32'hDEAD_BEEF; n_timeout = 1'b1;
        end
        @(posedge clk);
        #1;
        m_flag = n_flag; m_result = n_result; m_wdog = n_wdog; m_cycles = n_cycles;
        m_signal = n_signal; m_timeout = n_timeout;
        check_eq("rvalid", {31'd0, bus.data_rvalid_o}, {31'd0, req});
        check_eq("err",    {31'd0, bus.data_err_o},    {31'd0, e_err});
        check_eq("rdata",  bus.data_rdata_o, e_rdata);
        check_eq("flag",   mem_flag,   m_flag);
        check_eq("result", mem_result, m_result);
        check_eq("signal", {31'd0, signal},  {31'd0, m_signal});
        check_eq("timeout", {31'd0, timeout}, {31'd0, m_timeout});
    endtask

    task automatic do_reset();
        bus_idle();
        fe    = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic wr(input logic [31:0] ofs, input logic [3:0] be, input logic [31:0] wd);
        cycle(1'b1, 1'b1, c_base + ofs, be, wd);
    endtask

    task automatic rd(input logic [31:0] addr);
        cycle(1'b1, 1'b0, addr, 4'hF, 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'd0, 4'h0, 32'd0);
    endtask

    initial begin
        logic [31:0] addr_tab [8];
        addr_tab = '{c_base + 32'h0, c_base + 32'h4, c_base + 32'h8, c_base + 32'hC,
                     c_base + 32'h10, c_base + 32'h14, c_base + 32'h2, 32'h0020_0004};

        do_reset();
        #1;
        check_eq("rst_flag",    mem_flag,   32'd0);
        check_eq("rst_result",  mem_result, 32'd0);
        check_eq("rst_rvalid",  {31'd0, bus.data_rvalid_o}, 32'd0);
        check_eq("rst_timeout", {31'd0, timeout}, 32'd0);

        // Completion write sequence
        fe = 1'b1;
        wr(32'h4, 4'hF, 32'd42);
        check_eq("t1_result", mem_result, 32'd42);
        wr(32'h0, 4'hF, 32'd1);
        check_eq("t1_flag", mem_flag, 32'd1);

        // FLAG stickiness and RESULT freeze; counter frozen after completion
        do_reset();
        fe = 1'b1;
        wr(32'h4, 4'hF, 32'd7);
        wr(32'h0, 4'hF, 32'd3);
        wr(32'h4, 4'hF, 32'd99);
        wr(32'h0, 4'hF, 32'd5);
        check_eq("t2_flag", mem_flag, 32'd3);
        check_eq("t2_result", mem_result, 32'd7);
        rd(c_base + 32'hC);
        check_eq("t2_cycles_a", bus.data_rdata_o, 32'd2);
        idle(9);
        rd(c_base + 32'hC);
        check_eq("t2_cycles_b", bus.data_rdata_o, 32'd2);

        // Single byte lane
        do_reset();
        wr(32'h4, 4'b0100, 32'hAABB_CCDD);
        check_eq("t3_be", mem_result, 32'h00BB_0000);
        wr(32'h8, 4'h0, 32'hFFFF_FFFF);
        wr(32'h8, 4'h1, 32'hFFFF_FFFF);
        rd(c_base + 32'h8);

        // Watchdog expiry on the 100th enabled cycle
        do_reset();
        fe = 1'b1;
        idle(99);
        check_eq("t4_pre_flag", mem_flag, 32'd0);
        idle(1);
        check_eq("t4_flag", mem_flag, 32'd2);
        check_eq("t4_result", mem_result, 32'hDEAD_BEEF);
        check_eq("t4_timeout", {31'd0, timeout}, 32'd1);

        // Firmware completion on the expiry cycle wins
        do_reset();
        fe = 1'b1;
        idle(99);
        wr(32'h0, 4'hF, 32'd1);
        check_eq("t4b_flag", mem_flag, 32'd1);
        check_eq("t4b_timeout", {31'd0, timeout}, 32'd0);

        // RESULT write on the expiry cycle loses
        do_reset();
        fe = 1'b1;
        wr(32'h10, 4'hF, 32'd5);
        idle(3);
        wr(32'h4, 4'hF, 32'h1234_5678);
        check_eq("t4c_result", mem_result, 32'hDEAD_BEEF);

        // Decode misses
        do_reset();
        wr(32'h4, 4'hF, 32'h5555_AAAA);
        rd(c_base + 32'h14);
        rd(c_base + 32'h2);
        rd(32'h0020_0000);
        cycle(1'b1, 1'b1, 32'h0020_0004, 4'hF, 32'h0);
        check_eq("t5_result", mem_result, 32'h5555_AAAA);

        // Reset asserted while a read response is in flight
        do_reset();
        wr(32'h10, 4'hF, 32'd7);
        bus.data_req_i = 1'b1; bus.data_we_i = 1'b0; bus.data_addr_i = c_base;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        bus_idle();
        #1;
        check_eq("t6_rvalid_drop", {31'd0, bus.data_rvalid_o}, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_reset();
        idle(3);
        rd(c_base + 32'h10);
        check_eq("t6_wdog", bus.data_rdata_o, 32'd100);

        // Randomised traffic
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int k = 0; k < 200; k++) begin
                int          sel;
                logic [31:0] wd;
                fe  = ($urandom_range(0, 3) != 0);
                sel = (($urandom_range(0, 15)) == 0) ? 0 : $urandom_range(1, 7);
                wd  = $urandom();
                if (sel == 4) wd = $urandom_range(0, 200);
                cycle($urandom_range(0, 2) != 0, $urandom_range(0, 1) != 0,
                      addr_tab[sel], 4'($urandom_range(0, 15)), wd);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/soc_test_mailbox.md
Name: soc_test_mailbox

Overview:
- Memory-mapped test-status responder on the fault-tolerant core's data bus inside soc.
- Firmware writes a completion flag, a result word and a signal bit here; the block drives the soc-level `mem_flag`, `mem_result` and `signal` outputs that the bench monitors.
- It counts cycles since fetch enable.
- It forces a timeout flag if firmware never reports completion.

Parameters:
- BASE_ADDR, 32'h0010_0000, base of the 4 KiB mailbox window; only bits [31:12] are compared.
- TIMEOUT_DEFAULT, 32'd100, reset value of the WDOG_LIMIT register, in cycles; 0 disables the watchdog.
- TIMEOUT_CODE, 32'h0000_0002, value forced into FLAG on watchdog expiry.
- TIMEOUT_RESULT, 32'hDEAD_BEEF, value forced into RESULT on watchdog expiry.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- fetch_enable_i  in  1  core fetch enable; gates the cycle counter and watchdog
- data_req_i  in  1  request
- data_gnt_o  out  1  grant
- data_rvalid_o  out  1  response valid
- data_addr_i  in  32  byte address
- data_we_i  in  1  1 = write
- data_be_i  in  4  byte enables
- data_wdata_i  in  32  write data
- data_rdata_o  out  32  read data
- data_err_o  out  1  error, qualified by data_rvalid_o
- mem_flag  out  32  FLAG register
- mem_result  out  32  RESULT register
- signal  out  1  SIGNAL[0]
- timeout_o  out  1  sticky watchdog-expired indicator

Behaviour:
- Reset (async, rst_ni=0) values:
  - All outputs 0.
  - FLAG=0, RESULT=0, SIGNAL=0, CYCLES=0.
  - WDOG_LIMIT=TIMEOUT_DEFAULT.
  - No response pending.
- Handshake:
  - data_gnt_o = data_req_i, combinational; the responder is always ready.
  - A transaction is accepted on a rising edge with req & gnt.
  - data_rvalid_o is asserted exactly 1 cycle after acceptance, for 1 cycle.
  - Back-to-back accepts produce back-to-back rvalids; there is no stall.
  - data_rdata_o and data_err_o are valid only with rvalid; otherwise rdata=0 and err=0.
- Decode:
  - The access is a hit if addr[31:12]==BASE_ADDR[31:12], addr[1:0]==0 and offset addr[11:0] is a mapped register.
  - Anything else is a miss: err=1 and rdata=0 in the response cycle, and no state change.
- Register map (offset, access, function):
  - 0x00 FLAG, RW. Sticky: writes apply only while FLAG==0. Once FLAG is non-zero, further writes are ignored; only reset clears it.
  - 0x04 RESULT, RW. Writes are ignored once FLAG!=0, which freezes the result with completion.
  - 0x08 SIGNAL, RW. Bit 0 only; bits [31:1] read 0.
  - 0x0C CYCLES, RO. Writes to CYCLES are accepted with err=0 and ignored.
  - 0x10 WDOG_LIMIT, RW.
- Byte enables: each written byte lane updates only where be[n]=1. be=0000 is a legal no-op write.
- Write timing: register update at the acceptance edge. Outputs reflect the new value from the cycle after acceptance, i.e. the same cycle as rvalid.
- Read data: sampled at the acceptance edge. A read of CYCLES returns the counter value at acceptance.
- CYCLES counter:
  - Increments each cycle while fetch_enable_i=1 and FLAG==0.
  - Freezes once FLAG!=0.
  - Saturates at 32'hFFFF_FFFF with no wrap.
- Watchdog:
  - Armed while WDOG_LIMIT!=0.
  - On the edge where FLAG==0 and CYCLES+1 would reach WDOG_LIMIT (counting enabled): FLAG<=TIMEOUT_CODE, RESULT<=TIMEOUT_RESULT, timeout_o<=1.
- Simultaneous events:
  - Firmware FLAG write and watchdog expiry in the same cycle: the firmware write wins and timeout_o stays 0.
  - RESULT write and watchdog expiry in the same cycle: TIMEOUT_RESULT wins.
  - Lowering WDOG_LIMIT below CYCLES means no expiry, since the compare is equality. Firmware must set the limit above the current count.
- Reset mid-transaction: a pending rvalid is dropped and nothing is emitted after reset release.
- fetch_enable_i low pauses the counter; the bus remains fully functional.

Decomposition:
- Package soc_test_mailbox_pkg holds:
  - Register offset localparams: OFS_FLAG, OFS_RESULT, OFS_SIGNAL, OFS_CYCLES, OFS_WDOG.
  - A typedef for the registered response: valid, err, rdata.
  - A helper function applying byte enables to a 32-bit word.
- One natural sub-module, mailbox_watchdog: the cycle counter, saturation, equality compare and expiry pulse. The top module holds decode, the register file and the response stage.

Test Plan:
- Reset, fetch_enable_i=1, write FLAG=1 and RESULT=32'd42 at BASE_ADDR+0x04/+0x00 -> mem_result=42 and mem_flag=1 one cycle after each accept; rvalid 1 cycle after each gnt; err=0.
- Write RESULT=7, then FLAG=3, then RESULT=99 and FLAG=5 -> mem_flag stays 3, mem_result stays 7; a CYCLES read returns the same value on two reads 10 cycles apart.
- Byte-enable write be=0100, wdata=32'hAABBCCDD to RESULT (was 0) -> RESULT=32'h00BB0000.
- Never write FLAG, WDOG_LIMIT=100 -> on the 100th enabled cycle mem_flag=2, mem_result=32'hDEADBEEF, timeout_o=1; a same-cycle firmware FLAG=1 write instead gives mem_flag=1 and timeout_o=0.
- Read at BASE_ADDR+0x14, BASE_ADDR+0x02 and 32'h0020_0000 -> each gives rvalid with err=1, rdata=0; no register changes.
- Assert rst_ni=0 asynchronously the cycle after a granted read -> no rvalid appears after release; all outputs read 0 and WDOG_LIMIT=100.
